ro_freq_meter: RTL and testbench



---
 rtl/ro_fm_pkg.sv | 22 ++
 rtl/ro_freq_meter_pulse_sync_edge.sv | 33 +++
 rtl/ro_freq_meter.sv | 145 ++++++++++++++
 tb/tb_ro_freq_meter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_fm_pkg.sv
// Shared types and default constants for the ring-oscillator frequency meter.
// Optional build macro used by ro_freq_meter: RO_FM_CONTINUOUS_EN.
package ro_fm_pkg;

    localparam int DEF_WINDOW      = 1000;
    localparam int DEF_SETTLE      = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } fm_state_t;

    // Larger of two elaboration-time integers (used to size the shared timer).
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_freq_meter_pulse_sync_edge.sv
// Multi-flop synchroniser for the asynchronous oscillator pulse, followed by a
// rising-edge detector. rise is high for one clk cycle per synchronised 0->1.
module pulse_sync_edge
    import ro_fm_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    // Shift the async input through the synchroniser and keep the previous
    // synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_d;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: holds the oscillator in init while idle,
// releases it, waits SETTLE cycles, then counts synchronised rising edges over
// WINDOW clk cycles and reports a saturating count with a one-cycle done strobe.
// f_ro = count * f_clk / WINDOW; inputs at or above f_clk/2 alias.
//
// Handshake: start is level-sampled only in IDLE; busy is high from the cycle
// after acceptance until the return to IDLE; done is a single-cycle strobe and
// count/ovf are valid from that cycle until the next done or reset.
//
// Build macro RO_FM_CONTINUOUS_EN: when defined, start high in DONE restarts
// MEASURE directly with the oscillator still running. ro_init is registered, so
// its value during DONE is decided from start in the final MEASURE cycle.
module ro_freq_meter
    import ro_fm_pkg::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_pulse,
    output logic             ro_init,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output fm_state_t        dbg_state,
    output logic             dbg_sync
);

    localparam int TIMER_W = $clog2(max2(WINDOW, SETTLE) + 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW - 1);

    fm_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic               edge_ovf;
    logic               edge_rise;
    logic               cont_go;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(ro_pulse),
        .sync_out(dbg_sync),
        .rise    (edge_rise)
    );

`ifdef RO_FM_CONTINUOUS_EN
    assign cont_go = start;
`else
    assign cont_go = 1'b0;
`endif

    // Saturating edge counter value and sticky overflow if this cycle is counted.
    always_comb begin
        cnt_next = edge_cnt;
        ovf_next = edge_ovf;
        if (edge_rise) begin
            if (&edge_cnt) ovf_next = 1'b1;
            else           cnt_next = edge_cnt + CNT_W'(1);
        end
    end

    // Measurement FSM with registered oscillator control, status and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
            ro_init  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SETTLE;
                        timer   <= SETTLE_LOAD;
                        ro_init <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Edges seen here (including the last settle cycle) are dropped.
                    if (timer == '0) begin
                        state    <= ST_MEASURE;
                        timer    <= WINDOW_LOAD;
                        edge_cnt <= '0;
                        edge_ovf <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_MEASURE: begin
                    edge_cnt <= cnt_next;
                    edge_ovf <= ovf_next;
                    if (timer == '0) begin
                        // Final window cycle: its edge is included in the result.
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        count   <= cnt_next;
                        ovf     <= ovf_next;
                        ro_init <= ~cont_go;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_DONE: begin
                    if (cont_go) begin
                        state    <= ST_MEASURE;
                        timer    <= WINDOW_LOAD;
                        edge_cnt <= '0;
                        edge_ovf <= 1'b0;
                        ro_init  <= 1'b0;
                    end else begin
                        state   <= ST_IDLE;
                        ro_init <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ro_init <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter (WINDOW=100, SETTLE=4, CNT_W=4).
// Reference: the bench logs ro_pulse at every clk edge and counts rising
// transitions inside the measurement window using plain arithmetic.
module tb_ro_freq_meter;
  import ro_fm_pkg::*;

  localparam int W  = 100;
  localparam int S  = 4;
  localparam int CW = 4;
  localparam int SS = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ro_pulse;
  logic          ro_init;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          ovf;
  fm_state_t     dbg_state;
  logic          dbg_sync;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  ro_freq_meter #(.WINDOW(W), .SETTLE(S), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_pulse(ro_pulse),
    .ro_init(ro_init), .busy(busy), .done(done), .count(count), .ovf(ovf),
    .dbg_state(dbg_state), .dbg_sync(dbg_sync)
  );

  // ---------------- pulse sources ----------------
  int   sq_period = 10;
  int   sq_phase  = 0;
  int   sq_cnt    = 0;
  logic ro_sq     = 1'b0;
  logic ro_async  = 1'b0;
  logic async_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    sq_cnt = sq_cnt + 1;
    ro_sq = (((sq_cnt + sq_phase) % sq_period) < (sq_period / 2));
  end

  // Behavioural oscillator: stopped while ro_init=1, half-period 37 vs clk 10.
  initial forever begin
    #37;
    if (ro_init !== 1'b0) ro_async = 1'b0;
    else                  ro_async = ~ro_async;
  end

  assign ro_pulse = async_mode ? ro_async : ro_sq;

  // Log of ro_pulse as seen at each clk edge; index = edge number.
  logic hist[$];
  always @(posedge clk) hist.push_back(ro_pulse);

  // ---------------- reference model ----------------
  // Rising edges the meter sees at edges lo..hi: a 0->1 step in the logged
  // input, delayed by the synchroniser depth.
  function automatic int model_edges(input int lo, input int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++)
      if (hist[t-SS] === 1'b1 && hist[t-SS-1] === 1'b0) n++;
    return n;
  endfunction

  function automatic logic [CW-1:0] sat_cnt(input int n);
    return (n > CMAX) ? CW'(CMAX) : CW'(n);
  endfunction

  logic [CW-1:0] exp_q[$];

  // ---------------- driver ----------------
  int k0, k_acc, done_e, n_low, n_busy;
  bit busy_drop, timed_out;

  // Pulse start for one cycle (optionally re-pulse mid-run) and follow the run
  // to its done strobe. Called at #1 after an edge; returns at #1 after the
  // edge that made done visible.
  task automatic run_one(input bit repulse);
    k0 = hist.size() - 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_acc = hist.size() - 1;
    n_low = 0; n_busy = 0; busy_drop = 0; timed_out = 1; done_e = -1;
    for (int i = 0; i < 400; i++) begin
      int e;
      e = hist.size() - 1;
      if (ro_init === 1'b0) n_low++;
      if (busy === 1'b1) n_busy++; else busy_drop = 1;
      if (done === 1'b1) begin
        done_e = e; timed_out = 0;
        break;
      end
      start = repulse && ((e - k_acc) == 20 || (e - k_acc) == 50);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    idle_cycles(3);
    n_tests++; if (ro_init !== 1'b1) begin n_fail++; $display("FAIL reset_ro_init: got %0b expected 1", ro_init); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_tests++; if (dbg_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %0b expected 0", dbg_sync); end
    rst = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_basic;
    int n;
    sq_period = 10; sq_phase = 3;
    idle_cycles(4);
    run_one(1'b0);
    n = model_edges(k_acc + S + 1, k_acc + S + W);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within 400 cycles"); end
    n_tests++; if (done_e - k0 != S + W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", done_e - k0, S + W + 1); end
    n_tests++; if (n_low != S + W) begin n_fail++; $display("FAIL basic_ro_init_low: got %0d expected %0d", n_low, S + W); end
    n_tests++; if (n_busy != S + W + 1) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected %0d", n_busy, S + W + 1); end
    n_tests++; if (count !== 4'd10) begin n_fail++; $display("FAIL basic_count: got %0d expected 10", count); end
    n_tests++; if (count !== sat_cnt(n)) begin n_fail++; $display("FAIL basic_count_model: got %0d expected %0d", count, sat_cnt(n)); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %0b expected 0", ovf); end
    idle_cycles(1);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0 || ro_init !== 1'b1) begin
      n_fail++; $display("FAIL basic_after_done: got done=%0b busy=%0b ro_init=%0b expected 0 0 1", done, busy, ro_init);
    end
    n_tests++; if (count !== 4'd10) begin n_fail++; $display("FAIL basic_count_hold: got %0d expected 10", count); end
  endtask

  task automatic test_saturate;
    int n;
    sq_period = 2; sq_phase = 0;
    idle_cycles(3);
    run_one(1'b0);
    n = model_edges(k_acc + S + 1, k_acc + S + W);
    n_tests++; if (count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", count); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %0b expected 1", ovf); end
    n_tests++; if (ovf !== (n > CMAX)) begin n_fail++; $display("FAIL sat_ovf_model: got %0b expected %0b", ovf, n > CMAX); end
    sq_period = 20; sq_phase = 7;
    idle_cycles(3);
    run_one(1'b0);
    n = model_edges(k_acc + S + 1, k_acc + S + W);
    n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL slow_count: got %0d expected 5", count); end
    n_tests++; if (count !== sat_cnt(n)) begin n_fail++; $display("FAIL slow_count_model: got %0d expected %0d", count, sat_cnt(n)); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL slow_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_repulse;
    int n, extra;
    sq_period = 10; sq_phase = 1;
    idle_cycles(2);
    run_one(1'b1);
    n = model_edges(k_acc + S + 1, k_acc + S + W);
    n_tests++; if (busy_drop) begin n_fail++; $display("FAIL repulse_busy: got busy drop mid-run expected none"); end
    n_tests++; if (done_e - k0 != S + W + 1) begin n_fail++; $display("FAIL repulse_latency: got %0d expected %0d", done_e - k0, S + W + 1); end
    n_tests++; if (count !== sat_cnt(n)) begin n_fail++; $display("FAIL repulse_count: got %0d expected %0d", count, sat_cnt(n)); end
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL repulse_extra_run: got %0d busy/done cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int n, extra;
    sq_period = 10; sq_phase = 0;
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(S + 30);
    n_tests++; if (dbg_state !== ST_MEASURE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_MEASURE); end
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    n_tests++; if (ro_init !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got ro_init=%0b busy=%0b done=%0b expected 1 0 0", ro_init, busy, done);
    end
    n_tests++; if (count !== '0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got count=%0d ovf=%0b expected 0 0", count, ovf); end
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d dones expected 0", extra); end
    run_one(1'b0);
    n = model_edges(k_acc + S + 1, k_acc + S + W);
    n_tests++; if (timed_out || count !== sat_cnt(n)) begin n_fail++; $display("FAIL rstmid_rerun: got %0d expected %0d", count, sat_cnt(n)); end
  endtask

  task automatic test_back_to_back;
    int d[$];
    int low_gap, n, ks;
    sq_period = 12; sq_phase = 5;
    k0 = hist.size() - 1;
    start = 1'b1;
    low_gap = 0;
    for (int i = 0; i < 600 && d.size() < 2; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) d.push_back(hist.size() - 1);
      else if (d.size() == 1 && busy === 1'b0) low_gap++;
    end
    start = 1'b0;
    n_tests++; if (d.size() != 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", d.size()); end
    else begin
      ks = d[0] + 2;
      n = model_edges(ks + S + 1, ks + S + W);
      n_tests++; if (d[1] - d[0] != S + W + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", d[1] - d[0], S + W + 2); end
      n_tests++; if (low_gap != 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected 1", low_gap); end
      n_tests++; if (count !== sat_cnt(n)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", count, sat_cnt(n)); end
    end
    idle_cycles(S + W + 10);
  endtask

`ifdef RO_FM_CONTINUOUS_EN
  task automatic test_continuous;
    int d[$];
    int init_hi, n;
    sq_period = 8; sq_phase = 2;
    k0 = hist.size() - 1;
    start = 1'b1;
    init_hi = 0;
    for (int i = 0; i < 800 && d.size() < 3; i++) begin
      @(posedge clk); #1;
      if (ro_init === 1'b1) init_hi++;
      if (done === 1'b1) d.push_back(hist.size() - 1);
    end
    n_tests++; if (d.size() != 3) begin n_fail++; $display("FAIL cont_dones: got %0d expected 3", d.size()); end
    else begin
      n = model_edges(d[0] + 2, d[0] + W + 1);
      n_tests++; if (d[0] - k0 != S + W + 1) begin n_fail++; $display("FAIL cont_first: got %0d expected %0d", d[0] - k0, S + W + 1); end
      n_tests++; if (d[1] - d[0] != W + 1 || d[2] - d[1] != W + 1) begin
        n_fail++; $display("FAIL cont_period: got %0d,%0d expected %0d", d[1] - d[0], d[2] - d[1], W + 1);
      end
      n_tests++; if (init_hi != 0) begin n_fail++; $display("FAIL cont_ro_init: got %0d high cycles expected 0", init_hi); end
      n_tests++; if (d[1] > 0 && count !== sat_cnt(model_edges(d[1] + 2, d[1] + W + 1))) begin
        n_fail++; $display("FAIL cont_count: got %0d expected %0d", count, sat_cnt(model_edges(d[1] + 2, d[1] + W + 1)));
      end
      n_tests++; if (n < 0) begin n_fail++; $display("FAIL cont_model: got %0d expected >=0", n); end
    end
    start = 1'b0;
    idle_cycles(1);
    n_tests++; if (ro_init !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cont_stop: got ro_init=%0b busy=%0b expected 1 0", ro_init, busy);
    end
    idle_cycles(3);
  endtask
`endif

  task automatic test_async;
    async_mode = 1'b1;
    idle_cycles(5);
    run_one(1'b0);
    n_tests++; if (timed_out || count < 4'd13 || count > 4'd14) begin
      n_fail++; $display("FAIL async_count: got %0d expected 13..14", count);
    end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %0b expected 0", ovf); end
    async_mode = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_random;
    int n;
    logic [CW-1:0] exp_c;
    logic          exp_o;
    for (int r = 0; r < 8; r++) begin
      sq_period = $urandom_range(2, 40);
      sq_phase  = $urandom_range(0, 39);
      idle_cycles($urandom_range(1, 10));
      run_one(1'b0);
      n = model_edges(k_acc + S + 1, k_acc + S + W);
      exp_q.push_back(sat_cnt(n));
      exp_o = (n > CMAX);
      exp_c = exp_q.pop_front();
      n_tests++; if (timed_out || done_e - k0 != S + W + 1) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", r, done_e - k0, S + W + 1);
      end
      n_tests++; if (count !== exp_c) begin n_fail++; $display("FAIL rand_count[%0d] period=%0d: got %0d expected %0d", r, sq_period, count, exp_c); end
      n_tests++; if (ovf !== exp_o) begin n_fail++; $display("FAIL rand_ovf[%0d] period=%0d: got %0b expected %0b", r, sq_period, ovf, exp_o); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_repulse;
    test_reset_mid;
`ifdef RO_FM_CONTINUOUS_EN
    test_continuous;
`else
    test_back_to_back;
`endif
    test_async;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
